serial_add_ctrl: RTL

Bit-serial add/subtract controller that time-shares a single one-bit `sc2_block` full-adder cell across all bits of a WIDTH-bit operand pair. It accepts a start request, feeds one bit pair per clock into the cell LSB-first, and keeps the running carry in a flop. After WIDTH cycles it publishes the registered result with a one-cycle done pulse. It sits between a requesting datapath/sequencer and exactly one instance of `sc2_block`, which it instantiates internally.

---
 rtl/serial_add_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller wrapped around a single one-bit adder cell.
//
// state | meaning
// IDLE  | waiting for start; operands are latched on the accepting edge
// RUN   | one bit pair per clock through the cell, LSB first
// FIN   | result registers just updated; done is high for this one cycle

// One-bit combinational full adder shared across all operand bits.
module sc2_block (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic s_out,
  output logic c_out
);
  assign s_out = a_in ^ b_in ^ c_in;
  assign c_out = (a_in & b_in) | (c_in & (a_in ^ b_in));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  // One spare bit so the counter can never wrap before reaching WIDTH-1.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cell_s;
  logic             cell_c;
  logic             last_bit;

  sc2_block u_cell (
    .a_in  (sa[0]),
    .b_in  (sb[0]),
    .c_in  (carry),
    .s_out (cell_s),
    .c_out (cell_c)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at acc[0].
  generate
    if (WIDTH == 1) begin : g_acc_one
      assign acc_nxt = cell_s;
    end else begin : g_acc_wide
      assign acc_nxt = {cell_s, acc[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, carry flop, bit counter and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa       <= '0;
      sb       <= '0;
      acc      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          acc   <= acc_nxt;
          carry <= cell_c;
          cnt   <= cnt + CW'(1);
          // On the MSB cycle, carry still holds the carry into the MSB.
          if (last_bit) begin
            sum      <= acc_nxt;
            c_out    <= cell_c;
            overflow <= carry ^ cell_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
